// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the RegFile write-port arbiter.
// The wb_req_t struct is sized with the default address/data widths.
package rf_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  localparam int unsigned PRIO_RR    = 0;
  localparam int unsigned PRIO_FIXED = 1;

  // One-hot grant; GNT_NONE when nobody is served this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_REQ0 = 2'b01,
    GNT_REQ1 = 2'b10
  } grant_t;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_arb_grant.sv
// Grant logic for the two writeback requesters: round-robin or fixed
// priority to req0 with a saturating starvation counter for req1.
// Grant is combinational from the valids and internal state; forced to
// GNT_NONE while reset is high.
module rf_arb_grant
  import rf_arb_pkg::*;
#(
  parameter int unsigned PRIO_MODE  = PRIO_RR,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   valid0,
  input  logic   valid1,
  output grant_t grant
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic          last_grant;  // 1: req1 won last, so req0 wins the next tie
  logic [CW-1:0] starve_cnt;

  // Choose the winner for this cycle.
  always_comb begin
    grant = GNT_NONE;
    if (reset) begin
      grant = GNT_NONE;
    end else if (valid0 && valid1) begin
      if (PRIO_MODE == PRIO_FIXED) begin
        grant = (starve_cnt == STARVE_LIM) ? GNT_REQ1 : GNT_REQ0;
      end else begin
        grant = last_grant ? GNT_REQ0 : GNT_REQ1;
      end
    end else if (valid0) begin
      grant = GNT_REQ0;
    end else if (valid1) begin
      grant = GNT_REQ1;
    end
  end

  // Track the last winner and how long req1 has been losing.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      starve_cnt <= '0;
    end else begin
      if (grant == GNT_REQ0) begin
        last_grant <= 1'b0;
      end else if (grant == GNT_REQ1) begin
        last_grant <= 1'b1;
      end
      if (!valid1 || grant == GNT_REQ1) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the RegFile write port between ALU (req0) and memory (req1)
// writeback. Winner is registered into a one-cycle output stage; hazard
// flags cover the output stage and both pending requests.
// Optional macro RF_WR_ZERO_FILTER_EN: granted writes to address 0
// complete the handshake but never assert rf_wr.
module regfile_wr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned PRIO_MODE  = PRIO_RR,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_addr3,
  output logic [DW-1:0] rf_data3,
  input  logic [AW-1:0] query_addr1,
  input  logic [AW-1:0] query_addr2,
  output logic          hazard1,
  output logic          hazard2
);

  grant_t        grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          transfer;
  logic          write_en;

  rf_arb_grant #(
    .PRIO_MODE  (PRIO_MODE),
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant  (grant)
  );

  // Handshake and winner selection.
  always_comb begin
    req0_ready = (grant == GNT_REQ0);
    req1_ready = (grant == GNT_REQ1);
    transfer   = (grant != GNT_NONE);
    sel_addr   = req1_ready ? req1_addr : req0_addr;
    sel_data   = req1_ready ? req1_data : req0_data;
`ifdef RF_WR_ZERO_FILTER_EN
    write_en   = transfer && (sel_addr != '0);
`else
    write_en   = transfer;
`endif
  end

  // Output stage: one write per cycle, address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr    <= 1'b0;
      rf_addr3 <= '0;
      rf_data3 <= '0;
    end else begin
      rf_wr <= write_en;
      if (write_en) begin
        rf_addr3 <= sel_addr;
        rf_data3 <= sel_data;
      end
    end
  end

  // Read-after-write hazard flags for the two read addresses.
  always_comb begin
    hazard1 = (query_addr1 != '0) &&
              ((rf_wr      && rf_addr3  == query_addr1) ||
               (req0_valid && req0_addr == query_addr1) ||
               (req1_valid && req1_addr == query_addr1));
    hazard2 = (query_addr2 != '0) &&
              ((rf_wr      && rf_addr3  == query_addr2) ||
               (req0_valid && req0_addr == query_addr2) ||
               (req1_valid && req1_addr == query_addr2));
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a round-robin instance checked
// cycle by cycle against a small grant model, plus a fixed-priority
// instance checked against its expected grant pattern.
module tb_regfile_wr_arbiter;
  import rf_arb_pkg::*;

  typedef struct packed {
    logic    rst;
    wb_req_t w;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr, query_addr1, query_addr2;
  logic [31:0] req0_data, req1_data;

  logic        req0_ready, req1_ready, rf_wr, hazard1, hazard2;
  logic [4:0]  rf_addr3;
  logic [31:0] rf_data3;

  logic        fx_req0_ready, fx_req1_ready, fx_rf_wr, fx_hazard1, fx_hazard2;
  logic [4:0]  fx_rf_addr3;
  logic [31:0] fx_rf_data3;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sb_t         sb_q[$];
  logic        m_last;
  logic [4:0]  held_addr;
  logic [31:0] held_data;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.AW(5), .DW(32), .PRIO_MODE(0), .STARVE_MAX(3)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_wr(rf_wr), .rf_addr3(rf_addr3), .rf_data3(rf_data3),
    .query_addr1(query_addr1), .query_addr2(query_addr2), .hazard1(hazard1), .hazard2(hazard2)
  );

  regfile_wr_arbiter #(.AW(5), .DW(32), .PRIO_MODE(1), .STARVE_MAX(3)) u_fx (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fx_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fx_req1_ready),
    .rf_wr(fx_rf_wr), .rf_addr3(fx_rf_addr3), .rf_data3(fx_rf_data3),
    .query_addr1(query_addr1), .query_addr2(query_addr2), .hazard1(fx_hazard1), .hazard2(fx_hazard2)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic hz(input logic [4:0] q, input logic wr, input logic [4:0] wa);
    return (q != 5'd0) && ((wr && wa == q) ||
                           (req0_valid && req0_addr == q) ||
                           (req1_valid && req1_addr == q));
  endfunction

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // One clock: compare output stage to scoreboard, check grants, push expectation.
  task automatic cycle(input bit fx_chk, input bit fx_exp1, output logic g0, output logic g1);
    sb_t  e;
    sb_t  n;
    logic filt;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.rst) begin
        held_addr = '0;
        held_data = '0;
      end else if (e.w.valid) begin
        held_addr = e.w.addr;
        held_data = e.w.data;
      end
      check("rf_wr", 64'(rf_wr), 64'(e.w.valid));
      check("rf_addr3", 64'(rf_addr3), 64'(held_addr));
      check("rf_data3", 64'(rf_data3), 64'(held_data));
      check("hazard1", 64'(hazard1), 64'(hz(query_addr1, e.w.valid, held_addr)));
      check("hazard2", 64'(hazard2), 64'(hz(query_addr2, e.w.valid, held_addr)));
    end
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    if (fx_chk) begin
      check("fx_req0_ready", 64'(fx_req0_ready), 64'(!fx_exp1));
      check("fx_req1_ready", 64'(fx_req1_ready), 64'(fx_exp1));
    end
    n.rst    = reset;
    n.w.addr = g1 ? req1_addr : req0_addr;
    n.w.data = g1 ? req1_data : req0_data;
`ifdef RF_WR_ZERO_FILTER_EN
    filt = (n.w.addr == 5'd0);
`else
    filt = 1'b0;
`endif
    n.w.valid = (g0 || g1) && !filt;
    if (reset) m_last = 1'b1;
    else if (g0) m_last = 1'b0;
    else if (g1) m_last = 1'b1;
    sb_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    logic g0, g1;
    drive(0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, g0, g1);
  endtask

  task automatic pulse_reset();
    logic g0, g1;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cycle(0, 0, g0, g1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic g0, g1;
    logic p0v, p1v;
    logic [4:0] p0a, p1a;
    logic [31:0] p0d, p1d;
    m_last = 1'b1;
    held_addr = '0;
    held_data = '0;
    query_addr1 = '0;
    query_addr2 = '0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    cycle(0, 0, g0, g1);
    cycle(0, 0, g0, g1);
    reset = 1'b0;
    idle(1);

    // Single req0 write, then idle with held address/data.
    drive(1, 5'd1, 32'h00ff00ff, 0, 0, 0);
    cycle(0, 0, g0, g1);
    idle(3);

    // Both valid continuously: RR alternates, fixed gives 0,0,0,1 pattern.
    pulse_reset();
    drive(1, 5'd1, 32'haa55aa55, 1, 5'd2, 32'haa55aa55);
    for (int unsigned i = 0; i < 8; i++) cycle(1, (i % 4) == 3, g0, g1);
    idle(2);

    // Same destination on both requesters, hazard on query_addr1.
    pulse_reset();
    query_addr1 = 5'd5;
    query_addr2 = 5'd0;
    drive(1, 5'd5, 32'd1, 1, 5'd5, 32'd2);
    cycle(0, 0, g0, g1);
    drive(0, 5'd0, 32'd0, 1, 5'd5, 32'd2);
    cycle(0, 0, g0, g1);
    idle(2);
    query_addr1 = 5'd0;

    // Reset right after a transfer drops the in-flight write.
    drive(1, 5'd7, 32'h00001234, 0, 0, 0);
    cycle(0, 0, g0, g1);
    reset = 1'b1;
    drive(1, 5'd8, 32'h00005678, 1, 5'd9, 32'h9);
    cycle(0, 0, g0, g1);
    reset = 1'b0;
    idle(2);

    // Address 0 write: forwarded unless the zero filter is built in.
    drive(1, 5'd0, 32'hdeadbeef, 0, 0, 0);
    cycle(0, 0, g0, g1);
    idle(2);

    // Random traffic with requesters holding until granted.
    p0v = 0; p1v = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
    for (int unsigned i = 0; i < 60; i++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1; p0a = 5'($urandom_range(0, 7)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1; p1a = 5'($urandom_range(0, 7)); p1d = $urandom;
      end
      query_addr1 = 5'($urandom_range(0, 7));
      query_addr2 = 5'($urandom_range(0, 7));
      drive(p0v, p0a, p0d, p1v, p1a, p1d);
      cycle(0, 0, g0, g1);
      if (g0) p0v = 0;
      if (g1) p1v = 0;
    end
    query_addr1 = '0;
    query_addr2 = '0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
